// File: rtl/up_counter.sv
// Up counter with run/stop control, synchronous load, one-shot mode, a
// terminal-count pulse and a saturating wrap counter.
module up_counter #(
    parameter int WIDTH   = 4,
    parameter int MAX_VAL = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             oneshot,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             done,
    output logic [7:0]       wraps,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_VAL);

    state_t           state, state_nxt;
    logic             mode_os, mode_os_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic             tc_nxt;
    logic [7:0]       wraps_nxt;
    logic [WIDTH-1:0] load_clamped;

    assign load_clamped = (load_val > MAX_CNT) ? MAX_CNT : load_val;

    // State register; count, tc and wraps ride along so every output is a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            mode_os <= 1'b0;
            count   <= '0;
            tc      <= 1'b0;
            wraps   <= '0;
        end else begin
            state   <= state_nxt;
            mode_os <= mode_os_nxt;
            count   <= count_nxt;
            tc      <= tc_nxt;
            wraps   <= wraps_nxt;
        end
    end

    // Priority: load > stop > start > counting.
    always_comb begin
        state_nxt   = state;
        mode_os_nxt = mode_os;
        count_nxt   = count;
        tc_nxt      = 1'b0;
        wraps_nxt   = wraps;
        if (load) begin
            count_nxt = load_clamped;
            if (state == DONE)
                state_nxt = IDLE;
        end else if (stop) begin
            state_nxt = IDLE;
        end else if (start && state != RUN) begin
            state_nxt   = RUN;
            mode_os_nxt = oneshot;
            if (state == DONE)
                count_nxt = '0;
        end else if (state == RUN) begin
            if (count < MAX_CNT) begin
                count_nxt = count + WIDTH'(1);
            end else if (!mode_os) begin
                count_nxt = '0;
                tc_nxt    = 1'b1;
                if (wraps != 8'hFF)
                    wraps_nxt = wraps + 8'd1;
            end else begin
                state_nxt = DONE;
                tc_nxt    = 1'b1;
            end
        end
    end

    always_comb begin
        busy      = (state == RUN);
        done      = (state == DONE);
        state_dbg = state;
    end

endmodule

// File: doc/up_counter.md
# up_counter

Parameterised up counter with run/stop control, synchronous load, a one-shot mode, a terminal-count pulse and a saturating wrap counter. It is the count-up counterpart of the team's down counter. It is used wherever a block needs an event or cycle count that rises from a loaded value to a programmable ceiling.

## Interface
- WIDTH, 4, count width in bits
- MAX_VAL, 15, terminal value; legal range 1 .. 2^WIDTH-1
- clk  input  1  clock; all logic on posedge
- reset  input  1  synchronous, active-high reset
- start  input  1  request to enter RUN; level sampled each posedge
- stop  input  1  request to leave RUN or DONE and go to IDLE
- oneshot  input  1  mode select, latched only on an accepted start
- load  input  1  synchronous load of load_val
- load_val  input  WIDTH  load value; clamped to MAX_VAL if larger
- count  output  WIDTH  current count
- tc  output  1  one-cycle terminal-count pulse
- busy  output  1  state == RUN
- done  output  1  state == DONE
- wraps  output  8  number of completed wraps, saturating at 255

## Operation
- States: IDLE, RUN, DONE. The one-shot mode is held in an internal bit, mode_os.
- Reset (highest priority): count=0, state=IDLE, mode_os=0, tc=0, busy=0, done=0, wraps=0.
- Priority per edge: reset > load > stop > start > counting.
- load:
  - count <= min(load_val, MAX_VAL).
  - RUN stays RUN, with no increment that edge.
  - IDLE stays IDLE.
  - DONE goes to IDLE.
  - tc=0 that edge.
  - stop and start in the same cycle as load are ignored.
- stop, no load:
  - RUN or DONE goes to IDLE, with count held.
  - In IDLE, no effect.
  - stop wins over a simultaneous start.
- start, no load or stop, in IDLE:
  - Goes to RUN; mode_os <= oneshot.
  - count is unchanged that edge; the first increment happens on the next edge.
- start in DONE: goes to RUN, count <= 0, mode_os <= oneshot.
- start in RUN: ignored; mode_os is unchanged.
- RUN counting, each edge with no higher-priority event:
  - count < MAX_VAL: count <= count+1, tc <= 0.
  - count == MAX_VAL and mode_os=0: count <= 0, tc <= 1, wraps <= wraps+1, saturating at 255 (further wraps leave 255).
  - count == MAX_VAL and mode_os=1: count holds MAX_VAL, state <= DONE, tc <= 1. wraps is not incremented.
- IDLE and DONE: count holds, tc=0.
- wraps is cleared only by reset.
- All outputs are registered. busy and done decode the state register directly. There is no combinational path from any input to any output.

## Timing
- Latency: start sampled at edge E makes busy=1 after E and gives the first increment at E+1.
- Free-running with MAX_VAL=M: the count sequence is 0..M,0..., so the period is M+1 cycles.
  - tc is high for exactly the one cycle in which count shows the post-wrap 0.
  - wraps updates on the same edge as tc.
- One-shot:
  - The edge that sees count==M moves to DONE.
  - In the following cycle tc=1, done=1, busy=0 and count=M.
  - If the start is accepted with count already at M, DONE is reached on the first RUN edge.
- load during RUN: the loaded value is visible after the edge and increments resume on the next edge.
- reset asserted mid-RUN: all outputs reach their reset values after that edge, regardless of other inputs.
- tc never stays high for two consecutive cycles unless MAX_VAL... it never does, since MAX_VAL >= 1.

## Test plan
- Free-running wrap (WIDTH=4, MAX_VAL=15): reset, then start with oneshot=0 → count 0,1,...,15,0. tc=1 only while count=0 after the wrap. wraps=1 after 16 RUN edges and 2 after 32.
- MAX_VAL=9: run → count goes 9 → 0 with tc pulse; count never reaches 10. load_val=14 → count=9.
- One-shot: start with oneshot=1 from 0 → count reaches 15, then done=1, busy=0, tc pulses once, count holds 15 for 10 idle cycles. start again → count=0 after that edge, busy=1, then 1,2,...
- Load and stop:
  - load_val=12 while RUN at count 3 → count 12, then 13.
  - stop at count 7 → busy=0, count holds 7.
  - start again → 8 one edge after the following edge.
  - start and stop together in IDLE → remains IDLE.
- Reset mid-run at count 5 with start=1 → count=0, busy=0, done=0, tc=0, wraps=0 after the edge; stays IDLE until a new start.
- Saturation: free-run 300 wraps (MAX_VAL=15, 4800 cycles) → wraps=255 and holds. tc keeps pulsing every 16 cycles.
